// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types, widths and register encodings for the DDS sweep controller.
package dds_sweep_ctrl_pkg;

    localparam int unsigned F_W        = 24;
    localparam int unsigned STEP_W     = 16;
    localparam int unsigned DWELL_W    = 16;
    localparam int unsigned CFG_SEL_W  = 3;
    localparam int unsigned CFG_DATA_W = 16;
    localparam int unsigned CTRL_W     = 2;
    localparam int unsigned F_LO_W     = 16;
    localparam int unsigned F_HI_W     = F_W - F_LO_W;
    localparam int unsigned EXT_W      = F_W + 1;

    // cfg_sel encodings; 7 is unmapped
    localparam logic [CFG_SEL_W-1:0] CFG_START_HI = 3'd0;
    localparam logic [CFG_SEL_W-1:0] CFG_START_LO = 3'd1;
    localparam logic [CFG_SEL_W-1:0] CFG_STOP_HI  = 3'd2;
    localparam logic [CFG_SEL_W-1:0] CFG_STOP_LO  = 3'd3;
    localparam logic [CFG_SEL_W-1:0] CFG_STEP     = 3'd4;
    localparam logic [CFG_SEL_W-1:0] CFG_DWELL    = 3'd5;
    localparam logic [CFG_SEL_W-1:0] CFG_CTRL     = 3'd6;

    // ctrl register bit positions
    localparam int unsigned CTRL_TRI  = 0;
    localparam int unsigned CTRL_CONT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_STEP,
        ST_FINISH
    } state_t;

    // Reload value for a down-counter that must run max(len,1) cycles
    function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] len);
        return (len == '0) ? '0 : len - DWELL_W'(1);
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration, control and frequency-output bundle of the sweep controller.
interface dds_sweep_ctrl_if;
    import dds_sweep_ctrl_pkg::*;

    logic                  cfg_we;
    logic [CFG_SEL_W-1:0]  cfg_sel;
    logic [CFG_DATA_W-1:0] cfg_data;
    logic                  start;
    logic                  abort;
    logic [F_W-1:0]        fc_out;
    logic                  fc_valid;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cfg_we, cfg_sel, cfg_data, start, abort,
        input  fc_out, fc_valid, busy, done, err
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_data, start, abort,
        output fc_out, fc_valid, busy, done, err
    );

endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter: after a load, expire pulses on the max(len,1)-th cycle.
module dwell_timer
    import dds_sweep_ctrl_pkg::*;
(
    input  logic               CLK_50M,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] len,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt_q;
    logic               run_q;

    // Down-count from the reload value; expire marks the last counted cycle
    always_ff @(posedge CLK_50M) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            expire <= 1'b0;
        end else if (load) begin
            cnt_q  <= dwell_reload(len);
            run_q  <= 1'b1;
            expire <= (dwell_reload(len) == '0);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q  <= 1'b0;
                expire <= 1'b0;
            end else begin
                cnt_q  <= cnt_q - DWELL_W'(1);
                expire <= (cnt_q == DWELL_W'(1));
            end
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer driving a DDS carrier word (up, clamp, triangle, continuous).
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
(
    input  logic             CLK_50M,
    input  logic             rst_n,
    dds_sweep_ctrl_if.slave  bus
);

    state_t             state_q, state_d;
    logic [F_W-1:0]     fc_q, fc_d;
    logic               dir_down_q, dir_down_d;
    logic               fc_valid_q, fc_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [F_W-1:0]     start_f_q;
    logic [F_W-1:0]     stop_f_q;
    logic [STEP_W-1:0]  step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CTRL_W-1:0]  ctrl_q;

    logic               load_c;
    logic               expire;
    logic [EXT_W-1:0]   up_sum_c;
    logic signed [EXT_W-1:0] dn_diff_c;
    logic               unused_cfg_bits;

    assign unused_cfg_bits = ^bus.cfg_data[CFG_DATA_W-1:F_HI_W];

    // Configuration registers, writable only while idle
    always_ff @(posedge CLK_50M) begin
        if (!rst_n) begin
            start_f_q <= '0;
            stop_f_q  <= '0;
            step_q    <= '0;
            dwell_q   <= DWELL_W'(1);
            ctrl_q    <= '0;
        end else if (bus.cfg_we && !busy_q) begin
            case (bus.cfg_sel)
                CFG_START_HI: start_f_q[F_W-1 -: F_HI_W] <= bus.cfg_data[F_HI_W-1:0];
                CFG_START_LO: start_f_q[F_LO_W-1:0]      <= bus.cfg_data;
                CFG_STOP_HI:  stop_f_q[F_W-1 -: F_HI_W]  <= bus.cfg_data[F_HI_W-1:0];
                CFG_STOP_LO:  stop_f_q[F_LO_W-1:0]       <= bus.cfg_data;
                CFG_STEP:     step_q                     <= bus.cfg_data;
                CFG_DWELL:    dwell_q                    <= bus.cfg_data;
                CFG_CTRL:     ctrl_q                     <= bus.cfg_data[CTRL_W-1:0];
                default:      ;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK_50M) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fc_q       <= '0;
            dir_down_q <= 1'b0;
            fc_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            dir_down_q <= dir_down_d;
            fc_valid_q <= fc_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, next-frequency and pulse generation; abort overrides everything
    always_comb begin
        state_d    = state_q;
        fc_d       = fc_q;
        dir_down_d = dir_down_q;
        fc_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load_c     = 1'b0;
        up_sum_c   = EXT_W'(fc_q) + EXT_W'(step_q);
        dn_diff_c  = $signed(EXT_W'(fc_q)) - $signed(EXT_W'(step_q));

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((step_q != '0) && (start_f_q < stop_f_q)) begin
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                fc_d       = start_f_q;
                fc_valid_d = 1'b1;
                dir_down_d = 1'b0;
                state_d    = ST_DWELL;
            end
            ST_DWELL: begin
                if (expire) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (!dir_down_q && (fc_q != stop_f_q)) begin
                    fc_d       = (up_sum_c > EXT_W'(stop_f_q)) ? stop_f_q : up_sum_c[F_W-1:0];
                    fc_valid_d = 1'b1;
                    state_d    = ST_DWELL;
                end else if (!dir_down_q && !ctrl_q[CTRL_TRI]) begin
                    state_d = ST_FINISH;
                end else begin
                    // Down leg, including the turn-around cycle at stop_f
                    dir_down_d = 1'b1;
                    if (fc_q == start_f_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        fc_d       = (dn_diff_c < $signed(EXT_W'(start_f_q))) ?
                                     start_f_q : dn_diff_c[F_W-1:0];
                        fc_valid_d = 1'b1;
                        state_d    = ST_DWELL;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ctrl_q[CTRL_CONT] ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d    = ST_IDLE;
            fc_d       = fc_q;
            dir_down_d = dir_down_q;
            fc_valid_d = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end

        load_c = (state_d == ST_DWELL) && (state_q != ST_DWELL);
        busy_d = (state_d != ST_IDLE);
    end

    // Dwell timing, restarted on every entry into DWELL
    dwell_timer u_dwell_timer (
        .CLK_50M (CLK_50M),
        .rst_n   (rst_n),
        .load    (load_c),
        .len     (dwell_q),
        .expire  (expire)
    );

    assign bus.fc_out   = fc_q;
    assign bus.fc_valid = fc_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes expected pulses, monitor pops and compares.
module tb_dds_sweep_ctrl;

    localparam int K_FV   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [23:0] val;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #10 clk = ~clk;

    dds_sweep_ctrl_if bus ();

    dds_sweep_ctrl dut (
        .CLK_50M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    exp_t exp_q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   last_fv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got a pulse, expected none", name);
    endtask

    task automatic expect_ev(input int kind, input logic [23:0] v, input int gap);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.fc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                unexpected("fc_valid");
            end else begin
                e = exp_q.pop_front();
                check("fv_kind", e.kind, K_FV);
                check("fc_out", 32'(bus.fc_out), 32'(e.val));
                if (e.gap != 0) check("fv_spacing", cyc - last_fv, e.gap);
            end
            last_fv = cyc;
        end
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) unexpected("done");
            else begin
                e = exp_q.pop_front();
                check("done_kind", e.kind, K_DONE);
            end
        end
        if (bus.err === 1'b1) begin
            if (exp_q.size() == 0) unexpected("err");
            else begin
                e = exp_q.pop_front();
                check("err_kind", e.kind, K_ERR);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] sel, input logic [15:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_fc_out"},   32'(bus.fc_out),   32'd0);
        check({tag, "_fc_valid"}, 32'(bus.fc_valid), 32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_err"},      32'(bus.err),      32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = 3'd0;
        bus.cfg_data = 16'd0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic up sweep with dwell 3, plus start-to-first-valid latency
        cfg(3'd1, 16'd100);
        cfg(3'd3, 16'd130);
        cfg(3'd4, 16'd10);
        cfg(3'd5, 16'd3);
        expect_ev(K_FV, 24'd100, 0);
        expect_ev(K_FV, 24'd110, 4);
        expect_ev(K_FV, 24'd120, 4);
        expect_ev(K_FV, 24'd130, 4);
        expect_ev(K_DONE, 24'd0, 0);
        pulse_start();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("no_fv_in_load", 32'(bus.fc_valid), 32'd0);
        tick();
        check("latency_fv", 32'(bus.fc_valid), 32'd1);
        wait_idle("basic_idle", 100);
        wait_drain("basic_drain", 10);
        check("basic_hold", 32'(bus.fc_out), 32'd130);

        // Clamp to stop_f with dwell 1
        cfg(3'd1, 16'd0);
        cfg(3'd3, 16'd25);
        cfg(3'd5, 16'd1);
        expect_ev(K_FV, 24'd0, 0);
        expect_ev(K_FV, 24'd10, 2);
        expect_ev(K_FV, 24'd20, 2);
        expect_ev(K_FV, 24'd25, 2);
        expect_ev(K_DONE, 24'd0, 0);
        pulse_start();
        wait_idle("clamp_idle", 100);
        wait_drain("clamp_drain", 10);

        // Triangle continuous, abort after the second done
        cfg(3'd3, 16'd20);
        cfg(3'd6, 16'd3);
        for (int r = 0; r < 2; r++) begin
            expect_ev(K_FV, 24'd0, 0);
            expect_ev(K_FV, 24'd10, 2);
            expect_ev(K_FV, 24'd20, 2);
            expect_ev(K_FV, 24'd10, 2);
            expect_ev(K_FV, 24'd0, 2);
            expect_ev(K_DONE, 24'd0, 0);
        end
        expect_ev(K_FV, 24'd0, 0);
        pulse_start();
        wait_drain("tri_drain", 300);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("tri_abort_busy", 32'(bus.busy), 32'd0);
        check("tri_abort_hold", 32'(bus.fc_out), 32'd0);
        repeat (6) tick();
        check("tri_still_idle", 32'(bus.busy), 32'd0);
        cfg(3'd6, 16'd0);

        // Rejected starts: zero step, then start_f == stop_f
        cfg(3'd4, 16'd0);
        expect_ev(K_ERR, 24'd0, 0);
        pulse_start();
        check("rej_step_busy", 32'(bus.busy), 32'd0);
        tick();
        check("rej_step_busy2", 32'(bus.busy), 32'd0);
        wait_drain("rej_step_drain", 5);
        cfg(3'd4, 16'd10);
        cfg(3'd1, 16'd50);
        cfg(3'd3, 16'd50);
        expect_ev(K_ERR, 24'd0, 0);
        pulse_start();
        check("rej_eq_busy", 32'(bus.busy), 32'd0);
        tick();
        check("rej_eq_busy2", 32'(bus.busy), 32'd0);
        wait_drain("rej_eq_drain", 5);

        // Step write while busy is discarded
        cfg(3'd1, 16'd100);
        cfg(3'd3, 16'd130);
        cfg(3'd5, 16'd3);
        expect_ev(K_FV, 24'd100, 0);
        expect_ev(K_FV, 24'd110, 4);
        expect_ev(K_FV, 24'd120, 4);
        expect_ev(K_FV, 24'd130, 4);
        expect_ev(K_DONE, 24'd0, 0);
        pulse_start();
        tick();
        cfg(3'd4, 16'd99);
        wait_idle("busy_wr_idle", 100);
        wait_drain("busy_wr_drain", 10);

        // Start and abort together from IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_busy", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        check("sa_busy_later", 32'(bus.busy), 32'd0);
        check("sa_hold", 32'(bus.fc_out), 32'd130);

        // Top of range with clamp, then reset mid-DWELL
        cfg(3'd0, 16'h00FF);
        cfg(3'd1, 16'hFFF0);
        cfg(3'd2, 16'h00FF);
        cfg(3'd3, 16'hFFFF);
        cfg(3'd4, 16'h0020);
        cfg(3'd5, 16'd5);
        expect_ev(K_FV, 24'hFFFFF0, 0);
        expect_ev(K_FV, 24'hFFFFFF, 6);
        pulse_start();
        wait_drain("upper_drain", 50);
        check("upper_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        repeat (20) tick();
        check("post_reset_idle", 32'(bus.busy), 32'd0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
